// File: rtl/branch_ctrl.sv
// Branch control stage: decodes BEQ/BNE/HALT from the fetched instruction, maps the
// branch index to an absolute target through a writable LUT, and sequences a program run.
module branch_ctrl #(
   parameter int LUT_DEPTH = 16,
   parameter int PC_W      = 10,
   parameter int CNT_W     = 16
) (
   input  logic                         Clk,
   input  logic                         Reset_n,
   input  logic                         Start,
   input  logic [8:0]                   Instr,
   input  logic                         LutWrEn,
   input  logic [$clog2(LUT_DEPTH)-1:0] LutWrAddr,
   input  logic [PC_W-1:0]              LutWrData,
   output logic                         BranchOnEq,
   output logic                         BranchOnNe,
   output logic [PC_W-1:0]              Target,
   output logic                         Busy,
   output logic                         Done,
   output logic                         WrErr,
   output logic [CNT_W-1:0]             CycleCount
);

   localparam int IDX_W = $clog2(LUT_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t            state_q;
   logic              start_q;
   logic              busy_q;
   logic              done_q;
   logic              wr_err_q;
   logic              wr_err_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_d;
   logic [PC_W-1:0]   lut_q [LUT_DEPTH];

   logic              is_beq;
   logic              is_bne;
   logic              is_halt;
   logic              run_entry;
   logic              wr_accept;
   logic [IDX_W-1:0]  idx;

   assign is_beq    = (Instr[8:5] == 4'b1100);
   assign is_bne    = (Instr[8:5] == 4'b1101);
   assign is_halt   = (Instr == 9'h1FF);
   assign idx       = Instr[IDX_W-1:0];
   // Run begins on the falling edge of Start seen while idle.
   assign run_entry = (state_q == S_IDLE) && !Start && start_q;
   assign wr_accept = LutWrEn && (state_q != S_RUN);

   assign BranchOnEq = is_beq && busy_q;
   assign BranchOnNe = is_bne && busy_q;
   assign Target     = (is_beq || is_bne) ? lut_q[idx] : '0;
   assign Busy       = busy_q;
   assign Done       = done_q;
   assign WrErr      = wr_err_q;
   assign CycleCount = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (run_entry) begin
         cnt_d = '0;
      end else if (state_q == S_RUN && cnt_q != {CNT_W{1'b1}}) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_comb begin
      wr_err_d = wr_err_q;
      if (run_entry) begin
         wr_err_d = 1'b0;
      end else if (LutWrEn && state_q == S_RUN) begin
         wr_err_d = 1'b1;
      end
   end

   // Reads see the pre-write contents, so a same-cycle write/read returns the old entry.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < LUT_DEPTH; i++) begin
            lut_q[i] <= '0;
         end
      end else if (wr_accept) begin
         lut_q[LutWrAddr] <= LutWrData;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q  <= S_IDLE;
         start_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         cnt_q    <= '0;
         wr_err_q <= 1'b0;
      end else begin
         start_q  <= Start;
         cnt_q    <= cnt_d;
         wr_err_q <= wr_err_d;
         case (state_q)
            S_IDLE: begin
               if (run_entry) begin
                  state_q <= S_RUN;
                  busy_q  <= 1'b1;
               end
            end
            S_RUN: begin
               // An abort wins over a HALT presented on the same cycle.
               if (Start) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end else if (is_halt) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            S_DONE: begin
               if (Start) begin
                  state_q <= S_IDLE;
                  done_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
- Control stage that sits beside the program counter and drives its branch inputs.
- Watches the fetched 9-bit instruction and decodes BEQ/BNE.
- Converts a 4-bit branch index into a 10-bit absolute Target via a 16-entry lookup table, loaded by the bench before each program.
- Runs the program-sequencing FSM (Start handshake, HALT detection, Done) and counts execution cycles for the bench.

Parameters:
- LUT_DEPTH, 16, number of branch-target entries; index width = log2(LUT_DEPTH).
- PC_W, 10, target / program counter width.
- CNT_W, 16, cycle-counter width.

Ports:
- Clk  in  1  system clock; all state changes on posedge only.
- Reset_n  in  1  asynchronous, active-low reset.
- Start  in  1  program request from bench; held high while bench sets up, released to run.
- Instr  in  9  instruction currently addressed by ProgCtr (combinational ROM output).
- LutWrEn  in  1  LUT write strobe.
- LutWrAddr  in  4  LUT write index.
- LutWrData  in  PC_W  LUT write data.
- BranchOnEq  out  1  BEQ decoded; valid only in RUN.
- BranchOnNe  out  1  BNE decoded; valid only in RUN.
- Target  out  PC_W  absolute branch target.
- Busy  out  1  FSM in RUN.
- Done  out  1  FSM in DONE (program halted).
- WrErr  out  1  sticky flag: LUT write attempted during RUN.
- CycleCount  out  CNT_W  cycles spent in RUN for the current program.

Behaviour:
- Decode (combinational from Instr):
  - opcode = Instr[8:5]; 4'b1100 = BEQ; 4'b1101 = BNE; Instr == 9'h1FF = HALT; anything else is non-branch.
  - Branch index = Instr[3:0].
- Outputs by FSM state:
  - BranchOnEq = BEQ && state==RUN; BranchOnNe = BNE && state==RUN.
  - Target = LUT[Instr[3:0]] when BEQ or BNE, else 0.
  - Outside RUN, BranchOnEq/BranchOnNe = 0 while Target still reflects the decode.
- FSM states: IDLE, RUN, DONE; registered state, 1-cycle transitions.
  - IDLE: Start low with Start_q (Start registered one cycle) high, i.e. Start falling edge -> RUN. Otherwise stay.
  - RUN: HALT decoded -> DONE on the next edge. Start high -> IDLE (abort). Abort has priority over HALT.
  - DONE: Start high -> IDLE. Otherwise stay.
  - Start held high continuously keeps the FSM in IDLE.
- Cycle counter:
  - Cleared to 0 on the IDLE->RUN edge.
  - +1 on every edge while in RUN, including the edge that moves to DONE.
  - Saturates at all-ones (no wrap).
  - Holds in DONE and IDLE; cleared only on the next RUN entry.
- LUT:
  - 16 x PC_W registers.
  - Write on posedge when LutWrEn && state!=RUN.
  - A write during RUN is dropped and sets WrErr.
  - WrErr clears on the IDLE->RUN edge. A dropped write on that same edge is impossible (state is still IDLE), so the write is accepted.
  - Read is combinational from the current contents. A same-cycle read of the index being written returns the old value.
- Reset (Reset_n low, asynchronous): state=IDLE, Start_q=0, all LUT entries=0, CycleCount=0, WrErr=0.
  - Resulting outputs: Busy=0, Done=0, BranchOnEq=BranchOnNe=0.
  - Reset mid-RUN discards all progress; bench must reload the LUT.
- Latency:
  - Branch outputs are same-cycle with Instr (zero latency), so the program counter samples them on the same edge.
  - Done rises 1 cycle after HALT is presented in RUN.

Test Plan:
- Reset: assert Reset_n=0 mid-cycle -> outputs immediately IDLE values, LUT reads 0; release -> Busy=0, Done=0.
- LUT load + BEQ: in IDLE write LUT[3]=10'h155; pulse Start 1->0; present Instr=9'b1100_0_0011 in RUN -> BranchOnEq=1, BranchOnNe=0, Target=10'h155.
- BNE/non-branch: LUT[15]=10'h3FF, Instr=9'b1101_0_1111 -> BranchOnNe=1, Target=10'h3FF; Instr=9'h045 -> both branches 0, Target=0.
- HALT and count: start, run 5 cycles of non-branch, then Instr=9'h1FF -> next edge Done=1, Busy=0, CycleCount=6; further cycles hold 6; BEQ in DONE -> BranchOnEq=0.
- Write during RUN: LutWrEn=1, addr 2, data 10'h0AA while Busy -> LUT[2] unchanged, WrErr=1; Start 1->0 -> WrErr=0, CycleCount=0.
- Abort and saturation: Start high during RUN with HALT present -> IDLE (not DONE); force long run (>65535 cycles) -> CycleCount=16'hFFFF, no wrap.
